// File: rtl/sudoku_game_ctrl.sv
// sudoku_game_ctrl: game sequencer for the Sudoku board. It latches the difficulty,
// loads the puzzle rows, waits for the player and checks each row with the datapath.
`default_nettype none

module sudoku_game_ctrl #(
  parameter int N_ROWS = 9,
  parameter int RIDX_W = 4,
  parameter int DIFF_W = 2,
  parameter int MOVE_W = 8
) (
  input  logic              clka,
  input  logic              restart_n,
  input  logic              restart,
  input  logic              start,
  input  logic              enter,
  input  logic [DIFF_W-1:0] difficulty,
  input  logic              dp_valid,
  input  logic              dp_row_ok,
  output logic              load_en,
  output logic              dp_check,
  output logic [RIDX_W-1:0] ridx,
  output logic [N_ROWS-1:0] fill_flag,
  output logic [DIFF_W-1:0] diff_q,
  output logic [MOVE_W-1:0] moves,
  output logic [RIDX_W-1:0] bad_row,
  output logic              err,
  output logic              won,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PLAY    = 3'd2,
    S_CHECK   = 3'd3,
    S_WAIT_DP = 3'd4,
    S_WON     = 3'd5
  } state_t;

  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(N_ROWS - 1);

  state_t              state_q, state_d;
  logic [RIDX_W-1:0]   ridx_q, ridx_d;
  logic [N_ROWS-1:0]   fill_q, fill_d;
  logic [DIFF_W-1:0]   diff_d, diff_r;
  logic [MOVE_W-1:0]   moves_q, moves_d;
  logic [RIDX_W-1:0]   bad_q, bad_d;
  logic                err_q, err_d;
  logic                enter_q;
  logic                enter_rise;

  assign enter_rise = enter & ~enter_q;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= S_IDLE;
      ridx_q  <= '0;
      fill_q  <= '0;
      diff_r  <= '0;
      moves_q <= '0;
      bad_q   <= '0;
      err_q   <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ridx_q  <= ridx_d;
      fill_q  <= fill_d;
      diff_r  <= diff_d;
      moves_q <= moves_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      enter_q <= enter;
    end
  end

  always_comb begin
    state_d = state_q;
    ridx_d  = ridx_q;
    fill_d  = fill_q;
    diff_d  = diff_r;
    moves_d = moves_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    if (restart) begin
      // Difficulty survives a restart so the next game reuses it unless start re-latches.
      state_d = S_IDLE;
      ridx_d  = '0;
      fill_d  = '0;
      moves_d = '0;
      bad_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            diff_d  = difficulty;
            ridx_d  = '0;
            moves_d = '0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          fill_d = fill_q | (N_ROWS'(1) << ridx_q);
          if (ridx_q == LAST_ROW) begin
            ridx_d  = '0;
            state_d = S_PLAY;
          end else begin
            ridx_d = ridx_q + 1'b1;
          end
        end
        S_PLAY: begin
          if (enter_rise) begin
            if (moves_q != '1) moves_d = moves_q + 1'b1;
            ridx_d  = '0;
            state_d = S_CHECK;
          end
        end
        S_CHECK: state_d = S_WAIT_DP;
        S_WAIT_DP: begin
          if (dp_valid) begin
            if (!dp_row_ok) begin
              bad_d   = ridx_q;
              err_d   = 1'b1;
              state_d = S_PLAY;
            end else if (ridx_q == LAST_ROW) begin
              state_d = S_WON;
            end else begin
              ridx_d  = ridx_q + 1'b1;
              state_d = S_CHECK;
            end
          end
        end
        S_WON:   state_d = S_WON;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign load_en   = (state_q == S_LOAD);
  assign dp_check  = (state_q == S_CHECK);
  assign won       = (state_q == S_WON);
  assign state     = state_q;
  assign ridx      = ridx_q;
  assign fill_flag = fill_q;
  assign diff_q    = diff_r;
  assign moves     = moves_q;
  assign bad_row   = bad_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sudoku_game_ctrl.sv
// tb_sudoku_game_ctrl: directed bench with a row-index scoreboard; a second instance
// with a 2-bit move counter exercises saturation.
`default_nettype none

module tb_sudoku_game_ctrl;

  logic       clka = 1'b0;
  logic       restart_n, restart, start, enter, dp_valid, dp_row_ok;
  logic [1:0] difficulty;

  logic       load_en, dp_check, err, won;
  logic [3:0] ridx, bad_row;
  logic [8:0] fill_flag;
  logic [1:0] diff_q;
  logic [7:0] moves;
  logic [2:0] state;

  logic       load_en2, dp_check2, err2, won2;
  logic [3:0] ridx2, bad_row2;
  logic [8:0] fill_flag2;
  logic [1:0] diff_q2;
  logic [1:0] moves2;
  logic [2:0] state2;

  int checks = 0;
  int passes = 0;
  int exp_q[$];

  always #5 clka = ~clka;

  sudoku_game_ctrl #(.N_ROWS(9), .RIDX_W(4), .DIFF_W(2), .MOVE_W(8)) dut (
    .clka(clka), .restart_n(restart_n), .restart(restart), .start(start), .enter(enter),
    .difficulty(difficulty), .dp_valid(dp_valid), .dp_row_ok(dp_row_ok),
    .load_en(load_en), .dp_check(dp_check), .ridx(ridx), .fill_flag(fill_flag),
    .diff_q(diff_q), .moves(moves), .bad_row(bad_row), .err(err), .won(won), .state(state)
  );

  sudoku_game_ctrl #(.N_ROWS(9), .RIDX_W(4), .DIFF_W(2), .MOVE_W(2)) dut2 (
    .clka(clka), .restart_n(restart_n), .restart(restart), .start(start), .enter(enter),
    .difficulty(difficulty), .dp_valid(dp_valid), .dp_row_ok(dp_row_ok),
    .load_en(load_en2), .dp_check(dp_check2), .ridx(ridx2), .fill_flag(fill_flag2),
    .diff_q(diff_q2), .moves(moves2), .bad_row(bad_row2), .err(err2), .won(won2), .state(state2)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clka);
  endtask

  // Start a game and consume the load phase; optionally pulse enter mid-load.
  task automatic start_and_load(input logic [1:0] diff, input bit pulse_enter);
    int loads = 0;
    difficulty = diff;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_entry_state", state, 1);
    for (int r = 0; r < 9; r++) exp_q.push_back(r);
    for (int i = 0; i < 20 && state == 3'd1; i++) begin
      if (load_en && exp_q.size() > 0) begin
        chk("load_ridx", ridx, exp_q.pop_front());
        loads++;
      end
      if (pulse_enter) enter = (i == 3);
      step();
    end
    enter = 1'b0;
    chk("load_count", loads, 9);
    chk("load_q_drained", exp_q.size(), 0);
    chk("load_fill", fill_flag, 9'h1FF);
    chk("load_diff", diff_q, diff);
    chk("load_to_play", state, 2);
    chk("load_ridx_reset", ridx, 0);
  endtask

  // Rise enter in PLAY and answer each dp_check; fail_row<0 means every row passes.
  task automatic play_check(input int fail_row, input int hold);
    int  cyc = 0;
    bit  done = 1'b0;
    int  last = (fail_row < 0) ? 8 : fail_row;
    for (int r = 0; r <= last; r++) exp_q.push_back(r);
    enter = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      cyc++;
      if (cyc >= hold) enter = 1'b0;
      dp_valid = 1'b0;
      if (state == 3'd5 || state == 3'd2) begin
        done = 1'b1;
        break;
      end
      if (dp_check) begin
        if (exp_q.size() > 0) chk("check_ridx", ridx, exp_q.pop_front());
      end else if (state == 3'd4) begin
        dp_valid  = 1'b1;
        dp_row_ok = (int'(ridx) != fail_row);
      end
    end
    enter = 1'b0;
    dp_valid = 1'b0;
    chk("check_done", done, 1);
    chk("check_q_drained", exp_q.size(), 0);
    if (fail_row >= 0) begin
      chk("fail_state", state, 2);
      chk("fail_bad_row", bad_row, fail_row);
      chk("fail_err_pulse", err, 1);
      step();
      chk("fail_err_clear", err, 0);
      chk("fail_still_play", state, 2);
    end else begin
      chk("win_state", state, 5);
      chk("win_won", won, 1);
      chk("win_err", err, 0);
    end
  endtask

  initial begin
    restart_n = 1'b0; restart = 1'b0; start = 1'b0; enter = 1'b0;
    difficulty = 2'd0; dp_valid = 1'b0; dp_row_ok = 1'b0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_ridx", ridx, 0);
    chk("rst_fill", fill_flag, 0);
    chk("rst_moves", moves, 0);
    chk("rst_outs", {load_en, dp_check, err, won, diff_q, bad_row}, 0);
    enter = 1'b1;
    step();
    restart_n = 1'b1;
    step();
    chk("held_enter_idle", state, 0);
    enter = 1'b0;

    // Game 1: load at difficulty 2, then a held enter checks all rows and wins.
    start_and_load(2'd2, 1'b0);
    play_check(-1, 5);
    chk("win_moves", moves, 1);
    enter = 1'b1;
    step();
    enter = 1'b0;
    step();
    step();
    chk("won_enter_ignored_moves", moves, 1);
    chk("won_enter_ignored_state", state, 5);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("won_start_ignored", state, 5);

    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_state", state, 0);
    chk("restart_fill", fill_flag, 0);
    chk("restart_moves", moves, 0);
    chk("restart_diff_kept", diff_q, 2);

    // Game 2: enter pulse during load must be ignored; then failures and saturation.
    start_and_load(2'd1, 1'b1);
    chk("load_enter_ignored", moves, 0);
    play_check(4, 1);
    chk("fail_moves", moves, 1);
    chk("fail_moves_sat", moves2, 1);
    for (int k = 2; k <= 5; k++) begin
      play_check(0, 1);
      chk("sat_moves8", moves, k);
      chk("sat_moves2", moves2, (k > 3) ? 3 : k);
    end

    // Restart wins over dp_valid in WAIT_DP.
    enter = 1'b1;
    for (int i = 0; i < 10 && state != 3'd4; i++) step();
    enter = 1'b0;
    chk("reach_wait_dp", state, 4);
    dp_valid = 1'b1;
    dp_row_ok = 1'b1;
    restart = 1'b1;
    step();
    dp_valid = 1'b0;
    restart = 1'b0;
    chk("rs_dp_state", state, 0);
    chk("rs_dp_fill", fill_flag, 0);
    chk("rs_dp_moves", moves, 0);
    chk("rs_dp_bad_row", bad_row, 0);

    // Async reset mid-load at row 3 clears everything without a clock edge.
    difficulty = 2'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10 && !(state == 3'd1 && ridx == 4'd3); i++) step();
    chk("mid_load_ridx", ridx, 3);
    #2 restart_n = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_ridx", ridx, 0);
    chk("async_fill", fill_flag, 0);
    chk("async_diff", diff_q, 0);
    chk("async_outs", {load_en, dp_check, err, won, moves, bad_row}, 0);
    step();
    restart_n = 1'b1;
    step();
    chk("post_async_idle", state, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
